traffic_sensor_conditioner: RTL and testbench
=============================================

Name: traffic_sensor_conditioner

Overview:
Upstream front end of the four-road traffic light controller. It conditions raw loop-detector and siren-detector inputs from the field before the controller sees them:
- synchronises and debounces all 16 inputs;
- cleans each road's three density sensors into a thermometer level;
- arbitrates the four emergency requests into a clean zero-or-one-hot grant with a post-release hold.

Its outputs drive the controller's a1..d3 and ss1..ss4 inputs directly.

Parameters:
DEB_CYCLES, 8, consecutive differing synchronised samples required to flip a debounced bit (>=2)
EMG_HOLD, 16, cycles the emergency grant persists after the granted request drops (>=1)

Ports:
clock  in  1  system clock, all logic on posedge
clear  in  1  synchronous active-high reset
raw_det  in  12  raw detectors {a1,a2,a3,b1,b2,b3,c1,c2,c3,d1,d2,d3}, bit 11 = a1
raw_emg  in  4  raw siren detect {A,B,C,D}, bit 3 = road A
dens  out  12  conditioned densities, same bit order as raw_det
emg  out  4  emergency grant, zero or one-hot, same order as raw_emg
emg_active  out  1  OR of emg
fault  out  4  per-road non-thermometer sensor pattern, bit 3 = road A

Behaviour:
Reset and clocking:
- Only clocking is clock; clear is synchronous and active-high.
- On clear: synchronisers, debounce counters, stable bits, dens, emg, emg_active, fault and the hold timer go to 0; FSM goes to IDLE.
- clear wins over all other activity on the same edge.
- A bounce count in progress at clear is discarded.

Per-bit debounce (all 16 inputs):
- 2-flop synchroniser, then compare against the stable bit st.
- Sync value equals st: count = 0.
- Sync value differs: count increments. On the edge where count would reach DEB_CYCLES, st flips and count = 0.
- Any agreeing sample restarts the count.
- Counter width is $clog2(DEB_CYCLES+1).

Density cleanup (registered from st, per road with stable bits s1 s2 s3):
- dens = {s1, s1&s2, s1&s2&s3}.
- fault = (s2&~s1) | (s3&~s2).
- fault is a level, not sticky.

Latency:
- A raw change held stable appears on dens/fault DEB_CYCLES+3 edges after the first edge that samples it (11 for default).
- A pulse held fewer than DEB_CYCLES synchronised cycles never reaches the outputs.

Emergency FSM (on debounced emergency bits e[3:0]):
- IDLE: emg = 0. If any e is set, grant the highest index (A > B > C > D) and go to GRANT; emg becomes one-hot on the next edge.
- GRANT: stay while the granted e is high. When it goes low, load timer = EMG_HOLD-1 and go to HOLD.
- HOLD: emg unchanged.
  - Granted e reasserts: go to GRANT (no gap).
  - Else timer = 0: go to IDLE, emg = 0.
  - Else decrement the timer.
- IDLE always lasts at least one cycle between grants, so emg is 0 for >=1 cycle between different roads.
- No preemption: other roads' requests are ignored in GRANT/HOLD and are re-evaluated in IDLE.
- Simultaneous requests resolve by fixed priority only.
- emg_active is registered alongside emg and never disagrees with it.

Decomposition:
- Shared package traffic_pkg:
  - road index constants ROAD_A..ROAD_D (3..0);
  - sensor bit-position constants;
  - emergency FSM state encoding IDLE/GRANT/HOLD;
  - default DEB_CYCLES/EMG_HOLD.
- One sub-module, bit_debouncer (synchroniser + counter + stable bit, parameter DEB_CYCLES), instantiated 16 times.
- Thermometer cleanup and the emergency FSM stay in the top module.

Test Plan:
1. Reset: clear held 2 cycles with raw_det=12'hFFF, raw_emg=4'hF -> all outputs 0. After release, hold raw_det=12'hFFF -> dens=12'hFFF exactly at edge 11, still 0 at edge 10.
2. Glitch reject: raw a1 high 7 sync cycles then low -> dens stays 12'h000. Held 8 cycles -> dens[11:9]=3'b100 after latency.
3. Thermometer: road B raw=3'b011 stable -> dens[8:6]=3'b000, fault=4'b0100. Then B=3'b110 -> dens[8:6]=3'b110, fault=4'b0000.
4. Priority/hold: raw_emg=4'b0110 simultaneously -> emg=4'b0100, emg_active=1. B drops -> emg holds 4'b0100 for 16 cycles, then 4'b0000 for exactly 1 cycle, then 4'b0010.
5. Reassert in HOLD: B drops, then returns and debounces while the timer is mid-count -> emg stays 4'b0100 with no zero cycle, FSM back in GRANT.
6. Clear mid-grant: clear pulsed in GRANT with raw_emg=4'b1000 held -> emg=0 on the next edge. Re-grant 4'b1000 only after the full DEB_CYCLES+3 latency.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared road indices, sensor bit offsets and emergency FSM encoding
package traffic_pkg;

  localparam int DEF_DEB_CYCLES = 8;
  localparam int DEF_EMG_HOLD   = 16;

  localparam int ROAD_A = 3;
  localparam int ROAD_B = 2;
  localparam int ROAD_C = 1;
  localparam int ROAD_D = 0;

  // Each road owns three adjacent detector bits, density 1 in the top bit
  localparam int SENS_PER_ROAD = 3;
  localparam int S1_OFS = 2;
  localparam int S2_OFS = 1;
  localparam int S3_OFS = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } emg_state_t;

  function automatic logic [3:0] pick_road(input logic [3:0] req);
    logic [3:0] g;
    g = '0;
    if (req[ROAD_A])      g[ROAD_A] = 1'b1;
    else if (req[ROAD_B]) g[ROAD_B] = 1'b1;
    else if (req[ROAD_C]) g[ROAD_C] = 1'b1;
    else if (req[ROAD_D]) g[ROAD_D] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// rtl/traffic_sensor_conditioner_if.sv - raw field inputs and conditioned controller outputs
interface traffic_sensor_conditioner_if;
  logic [11:0] raw_det;
  logic [3:0]  raw_emg;
  logic [11:0] dens;
  logic [3:0]  emg;
  logic        emg_active;
  logic [3:0]  fault;

  modport master (output raw_det, raw_emg, input dens, emg, emg_active, fault);
  modport slave  (input raw_det, raw_emg, output dens, emg, emg_active, fault);
endinterface

// File: rtl/bit_debouncer.sv
// rtl/bit_debouncer.sv - two-flop synchroniser plus consecutive-sample debounce
module bit_debouncer #(
  parameter int DEB_CYCLES = 8
) (
  input  logic clock,
  input  logic clear,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          meta;
  logic          sync;
  logic          st;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (clear) begin
      meta <= 1'b0;
      sync <= 1'b0;
      st   <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      if (sync == st) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // this disagreeing sample is the DEB_CYCLES-th in a row
        st  <= ~st;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign dout = st;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// rtl/traffic_sensor_conditioner.sv - debounce, density thermometer cleanup, emergency arbitration
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int EMG_HOLD   = DEF_EMG_HOLD
) (
  input logic clock,
  input logic clear,
  traffic_sensor_conditioner_if.slave bus
);

  localparam int TW = $clog2(EMG_HOLD + 1);

  logic [15:0] raw_all;
  logic [15:0] st_all;
  logic [11:0] st_det;
  logic [3:0]  e;

  assign raw_all = {bus.raw_det, bus.raw_emg};
  assign st_det  = st_all[15:4];
  assign e       = st_all[3:0];

  for (genvar i = 0; i < 16; i++) begin : g_deb
    bit_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clock (clock),
      .clear (clear),
      .din   (raw_all[i]),
      .dout  (st_all[i])
    );
  end

  logic [11:0] dens_q, dens_nxt;
  logic [3:0]  fault_q, fault_nxt;

  always_comb begin
    dens_nxt  = '0;
    fault_nxt = '0;
    for (int r = 0; r < 4; r++) begin
      int b;
      b = r * SENS_PER_ROAD;
      dens_nxt[b+S1_OFS] = st_det[b+S1_OFS];
      dens_nxt[b+S2_OFS] = st_det[b+S1_OFS] & st_det[b+S2_OFS];
      dens_nxt[b+S3_OFS] = st_det[b+S1_OFS] & st_det[b+S2_OFS] & st_det[b+S3_OFS];
      fault_nxt[r] = (st_det[b+S2_OFS] & ~st_det[b+S1_OFS]) |
                     (st_det[b+S3_OFS] & ~st_det[b+S2_OFS]);
    end
  end

  emg_state_t    state, state_nxt;
  logic [3:0]    grant, grant_nxt;
  logic          active_q;
  logic [TW-1:0] timer, timer_nxt;

  always_ff @(posedge clock) begin
    if (clear) begin
      dens_q   <= '0;
      fault_q  <= '0;
      state    <= IDLE;
      grant    <= '0;
      active_q <= 1'b0;
      timer    <= '0;
    end else begin
      dens_q   <= dens_nxt;
      fault_q  <= fault_nxt;
      state    <= state_nxt;
      grant    <= grant_nxt;
      active_q <= |grant_nxt;
      timer    <= timer_nxt;
    end
  end

  // Only the granted road is watched outside IDLE; others wait for IDLE
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (|e) begin
          grant_nxt = pick_road(e);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!(|(e & grant))) begin
          timer_nxt = TW'(EMG_HOLD - 1);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (|(e & grant)) begin
          state_nxt = GRANT;
        end else if (timer == '0) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign bus.dens       = dens_q;
  assign bus.fault      = fault_q;
  assign bus.emg        = grant;
  assign bus.emg_active = active_q;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb/tb_traffic_sensor_conditioner.sv - directed self-checking bench for traffic_sensor_conditioner
module tb_traffic_sensor_conditioner;
  import traffic_pkg::*;

  logic clock;
  logic clear;
  int   n_cmp;
  int   n_err;

  traffic_sensor_conditioner_if bus ();

  traffic_sensor_conditioner dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    bus.raw_det = '0;
    bus.raw_emg = '0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // reset with all inputs high
    clear = 1'b1;
    bus.raw_det = 12'hFFF;
    bus.raw_emg = 4'hF;
    tick(2);
    chk("rst_dens", 32'(bus.dens), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_emg", 32'(bus.emg), 32'h0);
    chk("rst_active", 32'(bus.emg_active), 32'h0);

    // latency after release
    clear = 1'b0;
    tick(10);
    chk("lat_dens_e10", 32'(bus.dens), 32'h0);
    chk("lat_emg_e10", 32'(bus.emg), 32'h0);
    tick(1);
    chk("lat_dens_e11", 32'(bus.dens), 32'hFFF);
    chk("lat_fault_e11", 32'(bus.fault), 32'h0);
    chk("lat_emg_e11", 32'(bus.emg), 32'h8);
    chk("lat_active_e11", 32'(bus.emg_active), 32'h1);

    // glitch of 7 sync cycles is rejected
    do_clear();
    bus.raw_det = 12'h800;
    tick(7);
    bus.raw_det = 12'h000;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("glitch7_dens", 32'(bus.dens), 32'h0);
    end

    // 8 cycles is accepted
    do_clear();
    bus.raw_det = 12'h800;
    tick(8);
    bus.raw_det = 12'h000;
    tick(2);
    chk("pulse8_dens_e10", 32'(bus.dens), 32'h0);
    tick(1);
    chk("pulse8_dens_e11", 32'(bus.dens), 32'h800);

    // thermometer cleanup on road B
    do_clear();
    bus.raw_det = 12'h0C0;
    tick(11);
    chk("therm011_dens", 32'(bus.dens), 32'h0);
    chk("therm011_fault", 32'(bus.fault), 32'h4);
    bus.raw_det = 12'h180;
    tick(10);
    chk("therm110_fault_e10", 32'(bus.fault), 32'h4);
    tick(1);
    chk("therm110_dens", 32'(bus.dens), 32'h180);
    chk("therm110_fault", 32'(bus.fault), 32'h0);

    // simultaneous B and C: B wins
    do_clear();
    bus.raw_emg = 4'b0110;
    tick(10);
    chk("prio_emg_e10", 32'(bus.emg), 32'h0);
    tick(1);
    chk("prio_emg", 32'(bus.emg), 32'h4);
    chk("prio_active", 32'(bus.emg_active), 32'h1);

    // B drops then returns during the hold timer
    bus.raw_emg = 4'b0010;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      chk("reassert_emg", 32'(bus.emg), 32'h4);
      chk("reassert_active", 32'(bus.emg_active), 32'h1);
      if (i == 10) bus.raw_emg = 4'b0110;
      if (i == 15) chk("reassert_in_hold", 32'(dut.state), 32'(HOLD));
    end
    chk("reassert_grant", 32'(dut.state), 32'(GRANT));

    // B drops for good: 16-cycle hold, one idle cycle, then C
    bus.raw_emg = 4'b0010;
    for (int i = 1; i <= 26; i++) begin
      tick(1);
      chk("hold_emg", 32'(bus.emg), 32'h4);
    end
    tick(1);
    chk("gap_emg", 32'(bus.emg), 32'h0);
    chk("gap_active", 32'(bus.emg_active), 32'h0);
    tick(1);
    chk("next_emg", 32'(bus.emg), 32'h2);
    chk("next_active", 32'(bus.emg_active), 32'h1);

    // clear mid-grant
    do_clear();
    bus.raw_emg = 4'b1000;
    tick(11);
    chk("clr_pre_emg", 32'(bus.emg), 32'h8);
    clear = 1'b1;
    tick(1);
    chk("clr_emg", 32'(bus.emg), 32'h0);
    chk("clr_active", 32'(bus.emg_active), 32'h0);
    clear = 1'b0;
    tick(10);
    chk("clr_regrant_e10", 32'(bus.emg), 32'h0);
    tick(1);
    chk("clr_regrant_e11", 32'(bus.emg), 32'h8);
    chk("clr_regrant_active", 32'(bus.emg_active), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
